// File: rtl/posit_divide_seq_pkg.sv
// posit_divide_seq_pkg: posit field-width helpers and divider FSM state shared by the divider slice
package posit_divide_seq_pkg;
  typedef enum logic [1:0] {IDLE, DIV, DONE} divState_t;
  function automatic int getFractionBits(input int width, input int es);
    return width - 3 - es;
  endfunction
  function automatic int getExponentBias(input int width, input int es);
    return (width - 2) << es;
  endfunction
  function automatic int getMaxUnsignedExponent(input int width, input int es);
    return 2 * getExponentBias(width, es);
  endfunction
  function automatic int getUnsignedExponentBits(input int width, input int es);
    return $clog2(getMaxUnsignedExponent(width, es) + 1);
  endfunction
  function automatic int getNIter(input int fb, input int trailingBits);
    return fb + 1 + trailingBits;
  endfunction
  function automatic int getCounterWidth(input int nIter);
    return $clog2(nIter + 1);
  endfunction
endpackage

// File: rtl/posit_divide_seq_if.sv
// posit_divide_seq_if: operand/result handshake bundle for the sequential posit divider
interface posit_divide_seq_if #(
  parameter int WIDTH = 8,
  parameter int ES = 1,
  parameter int TRAILING_BITS = 2
);
  import posit_divide_seq_pkg::*;
  localparam int FB = getFractionBits(WIDTH, ES);
  localparam int UEB = getUnsignedExponentBits(WIDTH, ES);
  typedef struct packed {
    logic sign;
    logic isZero;
    logic isInf;
    logic [UEB-1:0] exponent;
    logic [FB-1:0] fraction;
  } PositUnpacked;
  logic inValid, inReady, outValid, outReady, stickyBit;
  PositUnpacked a, b, out;
  logic [TRAILING_BITS-1:0] trailingBits;
  modport master(output inValid, a, b, outReady, input inReady, out, trailingBits, stickyBit, outValid);
  modport slave(input inValid, a, b, outReady, output inReady, out, trailingBits, stickyBit, outValid);
endinterface

// File: rtl/posit_divide_seq_shift_right_sticky.sv
// ShiftRightSticky: logical right shift that ORs every bit shifted out into sticky
module ShiftRightSticky #(
  parameter int W = 8,
  parameter int SW = 4
) (
  input  logic [W-1:0]  in,
  input  logic [SW-1:0] shift,
  output logic [W-1:0]  out,
  output logic          sticky
);
  logic [2*W-1:0] wide;
  assign wide = {in, {W{1'b0}}} >> shift;
  assign out = wide[2*W-1:W];
  assign sticky = (int'(shift) >= W) ? |in : |wide[W-1:0];
endmodule

// File: rtl/posit_divide_seq.sv
// posit_divide_seq: non-pipelined restoring posit divider, one quotient bit per cycle, unrounded output
module posit_divide_seq
  import posit_divide_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ES = 1,
  parameter int TRAILING_BITS = 2
) (
  input logic clock,
  input logic reset,
  posit_divide_seq_if.slave io
);
  localparam int FB = getFractionBits(WIDTH, ES);
  localparam int UEB = getUnsignedExponentBits(WIDTH, ES);
  localparam int BIAS = getExponentBias(WIDTH, ES);
  localparam int MAX_EXP = getMaxUnsignedExponent(WIDTH, ES);
  localparam int N_ITER = getNIter(FB, TRAILING_BITS);
  localparam int CW = getCounterWidth(N_ITER);
  localparam int EW = UEB + 2;
  typedef struct packed {
    logic sign;
    logic isZero;
    logic isInf;
    logic [UEB-1:0] exponent;
    logic [FB-1:0] fraction;
  } PositUnpacked;
  divState_t state, stateNext;
  PositUnpacked a, b, outReg, outNext;
  logic [TRAILING_BITS-1:0] trailReg, trailNext;
  logic stickyReg, stickyNext;
  logic [FB:0] ma, mb, divisor, diff;
  logic [FB+1:0] rem, remNext;
  logic [N_ITER-1:0] q, qNext, frac;
  logic signed [EW-1:0] eq, eqIn;
  logic [EW-1:0] shiftAmt;
  logic [CW-1:0] count;
  logic qSign, adj, accept, special, infCase, qBit, lastIter, shiftSticky, remNz;
  assign a = io.a;
  assign b = io.b;
  assign accept = io.inValid && io.inReady;
  assign ma = {1'b1, a.fraction};
  assign mb = {1'b1, b.fraction};
  assign adj = ma < mb;
  assign infCase = a.isInf || b.isInf || b.isZero;
  assign special = infCase || a.isZero;
  assign eqIn = EW'(a.exponent) - EW'(b.exponent) + EW'(BIAS) - EW'(adj);
  assign qBit = rem >= {1'b0, divisor};
  assign diff = rem[FB:0] - divisor;
  assign remNext = {(qBit ? diff : rem[FB:0]), 1'b0};
  assign qNext = {q[N_ITER-2:0], qBit};
  assign remNz = remNext != '0;
  assign lastIter = count == CW'(N_ITER - 1);
  // frac holds 1.Q denormalised so that its MSB sits at weight 2^-1
  assign shiftAmt = ~eq;
  ShiftRightSticky #(.W(N_ITER), .SW(EW)) shifter (
    .in(qNext),
    .shift(shiftAmt),
    .out(frac),
    .sticky(shiftSticky)
  );
  always_comb begin
    stateNext = state;
    outNext = outReg;
    trailNext = trailReg;
    stickyNext = stickyReg;
    if (accept) begin
      stateNext = special ? DONE : DIV;
      outNext = '0;
      outNext.isInf = infCase;
      outNext.isZero = !infCase && a.isZero;
      trailNext = '0;
      stickyNext = 1'b0;
    end else if (state == DIV && lastIter) begin
      stateNext = DONE;
      outNext = '0;
      outNext.sign = qSign;
      trailNext = '0;
      stickyNext = 1'b0;
      if (!eq[EW-1] && eq[EW-2:0] > (EW-1)'(MAX_EXP)) outNext.exponent = UEB'(MAX_EXP);
      else if (eq[EW-1]) begin
        outNext.isZero = 1'b1;
        trailNext = frac[N_ITER-1 -: TRAILING_BITS];
        stickyNext = |frac[N_ITER-1-TRAILING_BITS:0] || shiftSticky || remNz;
      end else begin
        outNext.exponent = eq[UEB-1:0];
        outNext.fraction = qNext[N_ITER-2 -: FB];
        trailNext = qNext[TRAILING_BITS-1:0];
        stickyNext = remNz;
      end
    end else if (state == DONE && io.outReady) stateNext = IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      outReg <= '0;
      trailReg <= '0;
      stickyReg <= 1'b0;
      q <= '0;
      rem <= '0;
      divisor <= '0;
      eq <= '0;
      qSign <= 1'b0;
      count <= '0;
    end else begin
      state <= stateNext;
      outReg <= outNext;
      trailReg <= trailNext;
      stickyReg <= stickyNext;
      if (accept) begin
        divisor <= mb;
        rem <= adj ? {ma, 1'b0} : {1'b0, ma};
        q <= '0;
        count <= '0;
        eq <= eqIn;
        qSign <= a.sign ^ b.sign;
      end else if (state == DIV) begin
        rem <= remNext;
        q <= qNext;
        count <= count + CW'(1);
      end
    end
  end
  assign io.inReady = state == IDLE;
  assign io.outValid = state == DONE;
  assign io.out = outReg;
  assign io.trailingBits = trailReg;
  assign io.stickyBit = stickyReg;
endmodule

// File: tb/tb_posit_divide_seq.sv
// tb_posit_divide_seq: directed vectors with a scoreboard queue checked by an independent output monitor
module tb_posit_divide_seq;
  typedef struct packed {
    logic sign;
    logic isZero;
    logic isInf;
    logic [4:0] exponent;
    logic [3:0] fraction;
  } pu_t;
  typedef struct packed {
    pu_t out;
    logic [1:0] trail;
    logic sticky;
  } res_t;
  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int fails = 0;
  res_t sb[$];
  time acceptTime;
  posit_divide_seq_if #(.WIDTH(8), .ES(1), .TRAILING_BITS(2)) io();
  posit_divide_seq #(.WIDTH(8), .ES(1), .TRAILING_BITS(2)) dut (
    .clock(clock),
    .reset(reset),
    .io(io)
  );
  always #5 clock = ~clock;
  function automatic pu_t pu(input logic s, input logic z, input logic i, input logic [4:0] e, input logic [3:0] f);
    return {s, z, i, e, f};
  endfunction
  function automatic res_t r(input pu_t o, input logic [1:0] t, input logic s);
    return {o, t, s};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clock) begin : monitor
    res_t got, e;
    if (!reset && io.outValid && io.outReady) begin
      got = {io.out, io.trailingBits, io.stickyBit};
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL scoreboard: unexpected result %h", got);
      end else begin
        e = sb.pop_front();
        check("result", 32'(got), 32'(e));
      end
    end
  end
  task automatic waitIdle();
    int n = 0;
    while (!io.inReady && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!io.inReady) check("idle_timeout", 0, 1);
  endtask
  // called at posedge+1; returns at posedge+1 once outValid is visible
  task automatic send(input pu_t a, input pu_t b, input res_t e, input int lat);
    int cyc;
    io.a = a;
    io.b = b;
    io.inValid = 1'b1;
    waitIdle();
    @(posedge clock);
    acceptTime = $time;
    #1;
    io.inValid = 1'b0;
    io.a = pu(1, 0, 1, 5'h1f, 4'hf);
    io.b = pu(1, 1, 0, 5'h00, 4'h5);
    sb.push_back(e);
    cyc = 1;
    while (!io.outValid && cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(lat));
  endtask
  initial begin : stim
    res_t snap;
    time t0;
    io.inValid = 1'b0;
    io.outReady = 1'b1;
    io.a = '0;
    io.b = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_state", 32'({io.inReady, io.outValid, io.out, io.trailingBits, io.stickyBit}), 32'({1'b1, 1'b0, 15'd0}));
    send(pu(0, 0, 0, 12, 4'b1000), pu(0, 0, 0, 12, 4'b0000), r(pu(0, 0, 0, 12, 4'b1000), 2'b00, 0), 8);
    t0 = acceptTime;
    send(pu(0, 0, 0, 12, 4'b0000), pu(1, 0, 0, 12, 4'b1000), r(pu(1, 0, 0, 11, 4'b0101), 2'b01, 1), 8);
    check("period", 32'((acceptTime - t0) / 10), 9);
    send(pu(0, 0, 0, 12, 4'b0000), pu(0, 1, 0, 0, 0), r(pu(0, 0, 1, 0, 0), 2'b00, 0), 1);
    send(pu(0, 1, 0, 0, 0), pu(0, 0, 0, 13, 0), r(pu(0, 1, 0, 0, 0), 2'b00, 0), 1);
    send(pu(0, 1, 0, 0, 0), pu(0, 0, 1, 0, 0), r(pu(0, 0, 1, 0, 0), 2'b00, 0), 1);
    send(pu(1, 0, 1, 0, 0), pu(0, 0, 0, 12, 0), r(pu(0, 0, 1, 0, 0), 2'b00, 0), 1);
    send(pu(1, 0, 0, 24, 0), pu(0, 0, 0, 0, 0), r(pu(1, 0, 0, 24, 0), 2'b00, 0), 8);
    send(pu(0, 0, 0, 0, 0), pu(0, 0, 0, 24, 0), r(pu(0, 1, 0, 0, 0), 2'b00, 1), 8);
    send(pu(0, 0, 0, 14, 4'b1100), pu(0, 0, 0, 12, 4'b0100), r(pu(0, 0, 0, 14, 4'b0110), 2'b01, 1), 8);
    send(pu(0, 0, 0, 0, 0), pu(1, 0, 0, 13, 0), r(pu(1, 1, 0, 0, 0), 2'b10, 0), 8);
    send(pu(0, 0, 0, 0, 4'b1000), pu(0, 0, 0, 14, 0), r(pu(0, 1, 0, 0, 0), 2'b01, 1), 8);
    send(pu(0, 0, 0, 24, 4'b1000), pu(0, 0, 0, 12, 0), r(pu(0, 0, 0, 24, 4'b1000), 2'b00, 0), 8);
    send(pu(0, 0, 0, 24, 4'b1000), pu(0, 0, 0, 11, 0), r(pu(0, 0, 0, 24, 4'b0000), 2'b00, 0), 8);
    // consumer stall: result must hold and no new operand may be taken
    waitIdle();
    io.outReady = 1'b0;
    send(pu(0, 0, 0, 14, 4'b1100), pu(0, 0, 0, 12, 4'b0100), r(pu(0, 0, 0, 14, 4'b0110), 2'b01, 1), 8);
    snap = {io.out, io.trailingBits, io.stickyBit};
    io.inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check("stall_hold", 32'({io.inReady, io.outValid, io.out, io.trailingBits, io.stickyBit}), 32'({1'b0, 1'b1, snap}));
    end
    io.inValid = 1'b0;
    io.outReady = 1'b1;
    // reset in the third DIV cycle abandons the operation
    waitIdle();
    io.a = pu(0, 0, 0, 12, 4'b1000);
    io.b = pu(0, 0, 0, 12, 4'b0000);
    io.inValid = 1'b1;
    @(posedge clock);
    #1 io.inValid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    check("reset_mid_div", 32'({io.inReady, io.outValid, io.out, io.trailingBits, io.stickyBit}), 32'({1'b1, 1'b0, 15'd0}));
    reset = 1'b0;
    send(pu(0, 0, 0, 14, 4'b1100), pu(0, 0, 0, 12, 4'b0100), r(pu(0, 0, 0, 14, 4'b0110), 2'b01, 1), 8);
    waitIdle();
    repeat (2) @(posedge clock);
    #1 check("scoreboard_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
